// File: rtl/seg_display_ctrl.sv
// Binary-to-7-segment display controller: sequential double-dabble BCD conversion, one bit per clock.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module seg_display_ctrl #(
  parameter int NUM_WIDTH = 32,
  parameter int DIGITS    = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [NUM_WIDTH-1:0]   i_Num,
  input  logic                   i_Valid,
  output logic                   o_Ready,
  output logic [7*DIGITS-1:0]    o_Hex,
  output logic                   o_Overflow,
  output logic                   o_Done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(NUM_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  sticky_q, sticky_d;
  logic [7*DIGITS-1:0]   hex_q, hex_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic [BW-1:0]         bcd_adj;
  logic [7*DIGITS-1:0]   dec_hex;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                             : bcd_q[4*gi +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      // A digit is shown if it or any more significant digit is non-zero; digit 0 always shows.
      if (gi == 0) begin : g_lsd
        assign dec_hex[6:0] = seg_decode(bcd_q[3:0]);
      end else begin : g_upper
        assign dec_hex[7*gi +: 7] = (|bcd_q[BW-1:4*gi]) ? seg_decode(bcd_q[4*gi +: 4]) : 7'h7F;
      end
`else
      assign dec_hex[7*gi +: 7] = seg_decode(bcd_q[4*gi +: 4]);
`endif
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    sticky_d = sticky_q;
    hex_d    = hex_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Valid) begin
          shift_d  = i_Num;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // The post-adjust top bit is the one shifted out, so it marks a value too large for DIGITS.
        {bcd_d, shift_d} = {bcd_adj[BW-2:0], shift_q, 1'b0};
        if (bcd_adj[BW-1]) sticky_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) state_d = UPDATE;
      end
      UPDATE: begin
        ovf_d   = sticky_q;
        hex_d   = sticky_q ? {DIGITS{7'h3F}} : dec_hex;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      hex_q    <= {DIGITS{7'h7F}};
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      sticky_q <= sticky_d;
      hex_q    <= hex_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign o_Ready    = (state_q == IDLE);
  assign o_Hex      = hex_q;
  assign o_Overflow = ovf_q;
  assign o_Done     = done_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl (NUM_WIDTH=32, DIGITS=4): arithmetic reference model checked every cycle
// plus literal expectations per conversion. Honours SEG_LEADING_ZERO_BLANK_EN like the design.
module tb_seg_display_ctrl;

  localparam int NW = 32;
  localparam int ND = 4;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          i_Clk = 1'b0;
  logic          i_Rst;
  logic [NW-1:0] i_Num;
  logic          i_Valid;
  logic          o_Ready;
  logic [7*ND-1:0] o_Hex;
  logic          o_Overflow;
  logic          o_Done;

  seg_display_ctrl #(.NUM_WIDTH(NW), .DIGITS(ND)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Num(i_Num), .i_Valid(i_Valid),
    .o_Ready(o_Ready), .o_Hex(o_Hex), .o_Overflow(o_Overflow), .o_Done(o_Done)
  );

  initial forever #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected display computed from decimal arithmetic on the value.
  function automatic logic [7*ND-1:0] exp_hex(input logic [NW-1:0] n);
    logic [7*ND-1:0] r;
    longint v, p;
    int d;
    logic [6:0] s;
    r = '0;
    v = longint'(n);
    p = 1;
    for (int k = 0; k < ND; k++) begin
      d = int'((v / p) % 10);
      s = seg_of(d);
      if (LZB && k > 0 && v < p) s = 7'h7F;
      r[7*k +: 7] = s;
      p = p * 10;
    end
    if (v >= p) r = {ND{7'h3F}};
    return r;
  endfunction

  // Model: a conversion keeps the block busy for NW+1 cycles, then the result appears with a done pulse.
  int            m_busy = 0;
  logic [NW-1:0] m_num;
  logic          m_done, m_ovf, m_after_rst = 1'b0, chk_en = 1'b0;
  logic [7*ND-1:0] m_hex;

  always @(posedge i_Clk) begin
    m_after_rst <= i_Rst;
    if (i_Rst) begin
      m_busy <= 0;
      m_done <= 1'b0;
      m_hex  <= {ND{7'h7F}};
      m_ovf  <= 1'b0;
      chk_en <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_busy == 0) begin
        if (i_Valid) begin
          m_busy <= NW + 1;
          m_num  <= i_Num;
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_hex  <= exp_hex(m_num);
          m_ovf  <= (longint'(m_num) >= 64'd10000);
          m_done <= 1'b1;
        end
      end
    end
  end

  // Expectations handed over by the stimulus process.
  logic [7*ND-1:0] lit_hex;
  logic            lit_ovf;
  int              timeouts = 0;
  int              timeouts_seen = 0;
  int              low_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge i_Clk) begin
    if (chk_en) begin
      check("ready", 64'(o_Ready), 64'(m_busy == 0));
      check("done", 64'(o_Done), 64'(m_done));
      check("hex", 64'(o_Hex), 64'(m_hex));
      check("overflow", 64'(o_Overflow), 64'(m_ovf));
      if (m_after_rst) begin
        check("reset_hex", 64'(o_Hex), 64'h0FFF_FFFF);
        check("reset_ovf", 64'(o_Overflow), 64'd0);
        check("reset_done", 64'(o_Done), 64'd0);
      end
      if (o_Done) begin
        check("lit_hex", 64'(o_Hex), 64'(lit_hex));
        check("lit_ovf", 64'(o_Overflow), 64'(lit_ovf));
        check("busy_cycles", 64'(low_cnt), 64'd33);
      end
      if (timeouts != timeouts_seen) begin
        check("wait_bound", 64'(timeouts), 64'(timeouts_seen));
        timeouts_seen = timeouts;
      end
      if (o_Ready) low_cnt = 0;
      else         low_cnt++;
    end
  end

  task automatic start(input logic [NW-1:0] n);
    int c;
    c = 0;
    while (!o_Ready && c < 200) begin
      @(negedge i_Clk);
      c++;
    end
    if (c >= 200) timeouts++;
    i_Valid = 1'b1;
    i_Num   = n;
    @(negedge i_Clk);
    i_Valid = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!o_Done && c < 200) begin
      @(negedge i_Clk);
      c++;
    end
    if (c >= 200) timeouts++;
    @(negedge i_Clk);
  endtask

  task automatic run(input logic [NW-1:0] n, input logic [7*ND-1:0] hx, input logic ov);
    lit_hex = hx;
    lit_ovf = ov;
    start(n);
    wait_done();
  endtask

  initial begin
    i_Rst = 1'b1; i_Valid = 1'b0; i_Num = '0;
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    @(negedge i_Clk);

    run(32'd1234, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0);
    run(32'd9999, {7'h10, 7'h10, 7'h10, 7'h10}, 1'b0);
    run(32'd10000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1);
    run(32'hFFFF_FFFF, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1);
    if (LZB) begin
      run(32'd7,   {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0);
      run(32'd0,   {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0);
      run(32'd305, {7'h7F, 7'h30, 7'h40, 7'h12}, 1'b0);
    end else begin
      run(32'd7,   {7'h40, 7'h40, 7'h40, 7'h78}, 1'b0);
      run(32'd0,   {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
      run(32'd305, {7'h40, 7'h30, 7'h40, 7'h12}, 1'b0);
    end
    run(32'd1000, {7'h79, 7'h40, 7'h40, 7'h40}, 1'b0);

    // A request arriving mid-conversion must be dropped.
    lit_hex = {7'h79, 7'h24, 7'h30, 7'h19};
    lit_ovf = 1'b0;
    start(32'd1234);
    repeat (9) @(negedge i_Clk);
    i_Valid = 1'b1; i_Num = 32'd5678;
    @(negedge i_Clk);
    i_Valid = 1'b0;
    wait_done();
    run(32'd5678, {7'h12, 7'h02, 7'h78, 7'h00}, 1'b0);

    // Reset in the middle of a conversion aborts it without a done pulse.
    start(32'd4321);
    repeat (14) @(negedge i_Clk);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    repeat (40) @(negedge i_Clk);

    run(32'd42, LZB ? {7'h7F, 7'h7F, 7'h19, 7'h24} : {7'h40, 7'h40, 7'h19, 7'h24}, 1'b0);

    // Back-to-back requests with i_Valid held high.
    lit_hex = {7'h79, 7'h24, 7'h30, 7'h19};
    lit_ovf = 1'b0;
    i_Valid = 1'b1; i_Num = 32'd1234;
    repeat (3) @(negedge i_Clk);
    i_Valid = 1'b0;
    wait_done();
    repeat (5) @(negedge i_Clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1);
  end

endmodule
